// File: rtl/tage_tagged_table_if.sv
// tage_tagged_table_if: lookup, prediction and update bundle between the TAGE control logic and one tagged table.
interface tage_tagged_table_if #(
  parameter int HIST_LEN = 16,
  parameter int CTR_W    = 3,
  parameter int U_W      = 2
);
  logic                lookup_valid;
  logic [31:0]         lookup_pc;
  logic [HIST_LEN-1:0] lookup_ghr;
  logic                pred_valid;
  logic                pred_hit;
  logic                pred_taken;
  logic [CTR_W-1:0]    pred_ctr;
  logic [U_W-1:0]      pred_u;
  logic                ready;
  logic                update_valid;
  logic [31:0]         update_pc;
  logic [HIST_LEN-1:0] update_ghr;
  logic                update_taken;
  logic                update_provider;
  logic                update_altdiff;
  logic                update_alloc;
  logic [CTR_W-1:0]    update_ctr;
  logic [U_W-1:0]      update_u;
  logic                alloc_fail;
  modport master (
    output lookup_valid, lookup_pc, lookup_ghr, update_valid, update_pc, update_ghr, update_taken,
           update_provider, update_altdiff, update_alloc, update_ctr, update_u,
    input  pred_valid, pred_hit, pred_taken, pred_ctr, pred_u, ready, alloc_fail
  );
  modport slave (
    input  lookup_valid, lookup_pc, lookup_ghr, update_valid, update_pc, update_ghr, update_taken,
           update_provider, update_altdiff, update_alloc, update_ctr, update_u,
    output pred_valid, pred_hit, pred_taken, pred_ctr, pred_u, ready, alloc_fail
  );
endinterface

// File: rtl/tage_tagged_table.sv
// tage_tagged_table: tagged TAGE component with tag match, allocation, useful-bit aging and post-reset clear sweep.
module tage_tagged_table #(
  parameter int NUM_ENTRIES    = 1024,
  parameter int TAG_W          = 8,
  parameter int CTR_W          = 3,
  parameter int U_W            = 2,
  parameter int HIST_LEN       = 16,
  parameter int U_RESET_PERIOD = 262144
) (
  input logic clk,
  input logic rst,
  tage_tagged_table_if.slave tt_if
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WN  = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [U_W-1:0]   U_MAX   = '1;
  typedef enum logic [1:0] {INIT, RUN, UCLR} state_e;
  function automatic logic [31:0] fold(input logic [HIST_LEN-1:0] h, input int w);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < HIST_LEN; i++) f = f ^ (32'(h[i]) << (i % w));
    return f;
  endfunction
  function automatic logic [IDX_W-1:0] hash_idx(input logic [31:0] pc, input logic [HIST_LEN-1:0] h);
    logic [31:0] f;
    f = fold(h, IDX_W);
    return pc[IDX_W+1:2] ^ f[IDX_W-1:0];
  endfunction
  function automatic logic [TAG_W-1:0] hash_tag(input logic [31:0] pc, input logic [HIST_LEN-1:0] h);
    logic [31:0] f;
    f = fold(h, TAG_W) ^ (fold(h, TAG_W - 1) << 1);
    return pc[TAG_W+1:2] ^ f[TAG_W-1:0];
  endfunction
  state_e state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [31:0] cnt_q, cnt_d;
  logic [TAG_W+CTR_W-1:0] tc_mem [NUM_ENTRIES];
  logic [U_W-1:0] u_mem [NUM_ENTRIES];
  logic [TAG_W+CTR_W-1:0] tc_rd_q, tc_wd;
  logic [U_W-1:0] u_rd_q, u_wd;
  logic [IDX_W-1:0] lk_idx, up_idx, tc_wa, u_wa;
  logic [TAG_W-1:0] lk_tag, up_tag, tag_q;
  logic [CTR_W-1:0] ctr_sat, ctr_o;
  logic [U_W-1:0] u_sat;
  logic upd_ok, prov, alloc, alloc_new, tc_we, u_we, u_sweep, show;
  logic vld_q, rdy_q, uclr_q, afail_q;
  assign lk_idx    = hash_idx(tt_if.lookup_pc, tt_if.lookup_ghr);
  assign lk_tag    = hash_tag(tt_if.lookup_pc, tt_if.lookup_ghr);
  assign up_idx    = hash_idx(tt_if.update_pc, tt_if.update_ghr);
  assign up_tag    = hash_tag(tt_if.update_pc, tt_if.update_ghr);
  assign upd_ok    = tt_if.update_valid && state_q != INIT;
  assign prov      = upd_ok && tt_if.update_provider;
  assign alloc     = upd_ok && !tt_if.update_provider && tt_if.update_alloc;
  assign alloc_new = alloc && tt_if.update_u == '0;
  always_comb begin
    ctr_sat = tt_if.update_taken ? (tt_if.update_ctr == CTR_MAX ? CTR_MAX : tt_if.update_ctr + 1'b1)
                                 : (tt_if.update_ctr == '0 ? '0 : tt_if.update_ctr - 1'b1);
    u_sat   = (tt_if.update_ctr[CTR_W-1] == tt_if.update_taken)
              ? (tt_if.update_u == U_MAX ? U_MAX : tt_if.update_u + 1'b1)
              : (tt_if.update_u == '0 ? '0 : tt_if.update_u - 1'b1);
    tc_we   = state_q == INIT || prov || alloc_new;
    tc_wa   = state_q == INIT ? sweep_q : up_idx;
    tc_wd   = state_q == INIT ? {TAG_W'(0), CTR_WN}
            : prov ? {up_tag, ctr_sat}
            : {up_tag, tt_if.update_taken ? CTR_WT : CTR_WN};
    // Both INIT and UCLR own the u port; update u writes are dropped meanwhile.
    u_sweep = state_q != RUN;
    u_we    = u_sweep || (prov && tt_if.update_altdiff) || alloc;
    u_wa    = u_sweep ? sweep_q : up_idx;
    u_wd    = u_sweep ? '0 : prov ? u_sat : alloc_new ? '0 : tt_if.update_u - 1'b1;
  end
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    if (state_q != RUN) begin
      sweep_d = sweep_q + 1'b1;
      state_d = sweep_q == IDX_W'(NUM_ENTRIES - 1) ? RUN : state_q;
    end else if (upd_ok) begin
      cnt_d   = cnt_q == 32'(U_RESET_PERIOD - 1) ? '0 : cnt_q + 32'd1;
      state_d = cnt_q == 32'(U_RESET_PERIOD - 1) ? UCLR : RUN;
    end
  end
  // Write-first reads give the same-cycle update bypass.
  always_ff @(posedge clk) begin
    if (tc_we) tc_mem[tc_wa] <= tc_wd;
    if (u_we) u_mem[u_wa] <= u_wd;
    tc_rd_q <= (tc_we && tc_wa == lk_idx) ? tc_wd : tc_mem[lk_idx];
    u_rd_q  <= (u_we && u_wa == lk_idx) ? u_wd : u_mem[lk_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      uclr_q  <= 1'b0;
      tag_q   <= '0;
      afail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      vld_q   <= tt_if.lookup_valid;
      rdy_q   <= state_q != INIT;
      uclr_q  <= state_q == UCLR;
      tag_q   <= lk_tag;
      afail_q <= alloc && tt_if.update_u != '0;
    end
  end
  assign show             = vld_q && rdy_q;
  assign ctr_o            = show ? tc_rd_q[CTR_W-1:0] : '0;
  assign tt_if.pred_valid = vld_q;
  assign tt_if.pred_ctr   = ctr_o;
  assign tt_if.pred_taken = ctr_o[CTR_W-1];
  assign tt_if.pred_hit   = show && tc_rd_q[TAG_W+CTR_W-1:CTR_W] == tag_q;
  assign tt_if.pred_u     = (show && !uclr_q) ? u_rd_q : '0;
  assign tt_if.ready      = state_q != INIT;
  assign tt_if.alloc_fail = afail_q;
endmodule

// File: tb/tb_tage_tagged_table.sv
// tb_tage_tagged_table: random and directed traffic scored against an array-based model of the table.
module tb_tage_tagged_table;
  localparam int N = 16, IW = 4, TW = 8, CW = 3, UW = 2, HL = 16, P = 8;
  localparam int M_INIT = 0, M_RUN = 1, M_CLR = 2;
  localparam int WT = 1 << (CW - 1);
  localparam int CMAX = (1 << CW) - 1, UMAX = (1 << UW) - 1;
  typedef struct {bit full; bit hit; int ctr; int u;} pred_t;
  typedef struct {bit lv; bit rdy; bit af;} cyc_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  tage_tagged_table_if #(.HIST_LEN(HL), .CTR_W(CW), .U_W(UW)) tt_if();
  tage_tagged_table #(.NUM_ENTRIES(N), .TAG_W(TW), .CTR_W(CW), .U_W(UW), .HIST_LEN(HL),
                      .U_RESET_PERIOD(P)) dut (.clk(clk), .rst(rst), .tt_if(tt_if));
  pred_t pred_q[$];
  cyc_t cyc_q[$];
  int vectors = 0, miscompares = 0;
  int m_tag[N], m_ctr[N], m_u[N];
  int mode = M_INIT, sweep = 0, ucount = 0;
  int ghr_pool[4] = '{32'hA5A5, 32'h5A5A, 32'h0000, 32'hFFFF};
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int fold_m(input int h, input int w);
    int f = 0;
    int hm = h & ((1 << HL) - 1);
    for (int c = 0; c < HL; c += w) f ^= (hm >> c) & ((1 << w) - 1);
    return f;
  endfunction
  function automatic int hidx(input int pc, input int g);
    return ((pc >> 2) ^ fold_m(g, IW)) & (N - 1);
  endfunction
  function automatic int htag(input int pc, input int g);
    return ((pc >> 2) ^ fold_m(g, TW) ^ (fold_m(g, TW - 1) << 1)) & ((1 << TW) - 1);
  endfunction
  // Called at a negedge: drives one cycle, updates the model, returns at the next negedge.
  task automatic step(input bit lv, input int lpc, input int lghr, input bit uv, input int upc,
                      input int ughr, input bit tk, input bit prov, input bit altd, input bit alc,
                      input int uctr, input int uu);
    bit af = 0;
    int ui = hidx(upc, ughr), ut = htag(upc, ughr), li = hidx(lpc, lghr), lt = htag(lpc, lghr);
    pred_t e;
    cyc_t c;
    tt_if.lookup_valid = lv;       tt_if.lookup_pc = lpc;           tt_if.lookup_ghr = HL'(lghr);
    tt_if.update_valid = uv;       tt_if.update_pc = upc;           tt_if.update_ghr = HL'(ughr);
    tt_if.update_taken = tk;       tt_if.update_provider = prov;    tt_if.update_altdiff = altd;
    tt_if.update_alloc = alc;      tt_if.update_ctr = CW'(uctr);    tt_if.update_u = UW'(uu);
    if (mode == M_INIT) begin
      m_tag[sweep] = 0; m_ctr[sweep] = WT - 1; m_u[sweep] = 0;
    end else if (uv && prov) begin
      m_tag[ui] = ut;
      m_ctr[ui] = tk ? (uctr == CMAX ? CMAX : uctr + 1) : (uctr == 0 ? 0 : uctr - 1);
      if (altd && mode == M_RUN)
        m_u[ui] = ((uctr >= WT) == tk) ? (uu == UMAX ? UMAX : uu + 1) : (uu == 0 ? 0 : uu - 1);
    end else if (uv && alc) begin
      if (uu == 0) begin
        m_tag[ui] = ut; m_ctr[ui] = tk ? WT : WT - 1;
        if (mode == M_RUN) m_u[ui] = 0;
      end else begin
        af = 1;
        if (mode == M_RUN) m_u[ui] = uu - 1;
      end
    end
    if (mode == M_CLR) m_u[sweep] = 0;
    if (lv) begin
      e.full = mode != M_INIT;
      e.hit  = e.full && m_tag[li] == lt;
      e.ctr  = m_ctr[li];
      e.u    = mode == M_CLR ? 0 : m_u[li];
      pred_q.push_back(e);
    end
    if (mode != M_RUN) begin
      sweep++;
      if (sweep == N) begin sweep = 0; mode = M_RUN; end
    end else if (uv) begin
      ucount++;
      if (ucount == P) begin ucount = 0; mode = M_CLR; end
    end
    c.lv = lv; c.rdy = mode != M_INIT; c.af = af;
    cyc_q.push_back(c);
    @(negedge clk);
  endtask
  task automatic look(input int pc, input int g);
    step(1, pc, g, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rnd_step(input bit force_upd);
    step($urandom_range(0, 1), 32'h1000 + 4 * $urandom_range(0, 7), ghr_pool[$urandom_range(0, 3)],
         force_upd || $urandom_range(0, 1) == 1, 32'h1000 + 4 * $urandom_range(0, 7),
         ghr_pool[$urandom_range(0, 3)], $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, CMAX), $urandom_range(0, UMAX));
  endtask
  task automatic do_reset(input int cycles);
    rst = 1;
    tt_if.lookup_valid = 0;
    tt_if.update_valid = 0;
    pred_q.delete();
    cyc_q.delete();
    repeat (cycles) @(negedge clk);
    rst = 0;
    mode = M_INIT; sweep = 0; ucount = 0;
  endtask
  initial begin
    pred_t e;
    cyc_t c;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        chk("rst_pred_valid", tt_if.pred_valid, 0);
        chk("rst_ready", tt_if.ready, 0);
        chk("rst_alloc_fail", tt_if.alloc_fail, 0);
      end else begin
        if (cyc_q.size() == 0) chk("cycle_underflow", cyc_q.size(), 1);
        else begin
          c = cyc_q.pop_front();
          chk("ready", tt_if.ready, c.rdy);
          chk("alloc_fail", tt_if.alloc_fail, c.af);
          chk("pred_valid", tt_if.pred_valid, c.lv);
        end
        if (!tt_if.pred_valid)
          chk("idle_zero", {tt_if.pred_hit, tt_if.pred_taken, tt_if.pred_ctr, tt_if.pred_u}, 0);
        else if (pred_q.size() == 0) chk("pred_underflow", pred_q.size(), 1);
        else begin
          e = pred_q.pop_front();
          chk("pred_hit", tt_if.pred_hit, e.hit);
          if (e.full) begin
            chk("pred_ctr", tt_if.pred_ctr, e.ctr);
            chk("pred_taken", tt_if.pred_taken, e.ctr >= WT);
            chk("pred_u", tt_if.pred_u, e.u);
          end
        end
      end
    end
  end
  initial begin
    int guard;
    tt_if.lookup_valid = 0; tt_if.lookup_pc = 0; tt_if.lookup_ghr = 0;
    tt_if.update_valid = 0; tt_if.update_pc = 0; tt_if.update_ghr = 0; tt_if.update_taken = 0;
    tt_if.update_provider = 0; tt_if.update_altdiff = 0; tt_if.update_alloc = 0;
    tt_if.update_ctr = 0; tt_if.update_u = 0;
    @(negedge clk);
    do_reset(3);
    for (int i = 0; i < N; i++) look(32'h1000 + 4 * (i % 8), ghr_pool[i % 4]);
    for (int i = 0; i < 4; i++) look(32'h2000 + 4 * i, ghr_pool[i]);
    step(0, 0, 0, 1, 32'h1000, 32'hA5A5, 1, 0, 0, 1, 0, 0);
    look(32'h1000, 32'hA5A5);
    look(32'h1000, 32'h5A5A);
    step(1, 32'h1000, 32'hA5A5, 1, 32'h1000, 32'hA5A5, 1, 1, 0, 0, 7, 0);
    step(1, 32'h1000, 32'hA5A5, 1, 32'h1000, 32'hA5A5, 0, 1, 0, 0, 0, 0);
    step(1, 32'h1000, 32'hA5A5, 1, 32'h1000, 32'hA5A5, 1, 1, 1, 0, 4, 3);
    step(1, 32'h1000, 32'hA5A5, 1, 32'h1000, 32'hA5A5, 1, 1, 0, 0, 5, 2);
    step(1, 32'h1004, 32'h5A5A, 1, 32'h1000, 32'hA5A5, 1, 0, 0, 1, 5, 2);
    look(32'h1000, 32'hA5A5);
    step(1, 32'h1000, 32'hA5A5, 1, 32'h1000, 32'hA5A5, 0, 1, 0, 1, 5, 2);
    for (int i = 0; i < N + 4; i++) look(32'h1000 + 4 * (i % 8), ghr_pool[i % 4]);
    for (int i = 0; i < 2000; i++) rnd_step(0);
    guard = 0;
    while (mode != M_CLR && guard < 100) begin rnd_step(1); guard++; end
    chk("reach_uclr", mode, M_CLR);
    for (int i = 0; i < 5; i++) rnd_step(0);
    do_reset(2);
    for (int i = 0; i < N + 40; i++) rnd_step(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pred_drain", pred_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tage_tagged_table.md
Name: tage_tagged_table

Overview:
- Parametrised tagged TAGE component (T1..Tn) that sits beside the base predictor table in the fetch-stage direction predictor.
- Each entry holds a partial tag, a signed-style saturating prediction counter and a useful counter.
- Index and tag are hashes of the PC with history folded to a configurable length.
- Adds what the base table lacks: tag match, allocation on mispredict, useful-bit aging, and a hardware clear sweep after reset.

Parameters:
- NUM_ENTRIES, 1024, entries (power of 2); IDX_W = $clog2(NUM_ENTRIES)
- TAG_W, 8, partial tag width
- CTR_W, 3, prediction counter width
- U_W, 2, useful counter width
- HIST_LEN, 16, global history bits consumed (>= 1)
- U_RESET_PERIOD, 262144, updates between useful-bit clear sweeps

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lookup_valid  in  1  lookup request
- lookup_pc  in  32  branch PC
- lookup_ghr  in  HIST_LEN  global history at lookup
- pred_valid  out  1  response valid, one cycle after lookup_valid
- pred_hit  out  1  tag matched
- pred_taken  out  1  pred_ctr MSB
- pred_ctr  out  CTR_W  entry counter
- pred_u  out  U_W  entry useful counter
- ready  out  1  table initialised; low during the init sweep
- update_valid  in  1  update request
- update_pc  in  32  PC of the resolved branch
- update_ghr  in  HIST_LEN  history captured at prediction
- update_taken  in  1  resolved direction
- update_provider  in  1  this table was the provider
- update_altdiff  in  1  provider prediction differed from the alternate prediction
- update_alloc  in  1  allocate request (mispredict, longer-history candidate)
- update_ctr  in  CTR_W  counter read at prediction
- update_u  in  U_W  useful value read at prediction
- alloc_fail  out  1  one-cycle pulse: allocation refused, entry u decremented

Behaviour:
- Hashing:
  - fold(h, W) is the XOR of consecutive W-bit chunks of h; the last chunk is zero-padded.
  - idx = pc[IDX_W+1:2] ^ fold(ghr, IDX_W).
  - tag = pc[TAG_W+1:2] ^ fold(ghr, TAG_W) ^ (fold(ghr, TAG_W-1) << 1), truncated to TAG_W.
  - Identical functions are used for lookup and update.
- Storage: a tag+ctr RAM and a separate u RAM. Both are synchronous-read, one read and one write port each.
- Lookup: 1-cycle latency.
  - pred_* are registered and valid in the cycle after lookup_valid; all are zero when pred_valid=0.
  - pred_hit = (stored tag == registered lookup tag).
  - While ready=0: pred_valid follows lookup_valid, but pred_hit=0.
- Bypass: if an update writes idx X in the same cycle as a lookup of idx X, the response returns the newly written data.
- Update: applied in one cycle with no read-back; the write uses update_ctr and update_u.
  - Provider:
    - ctr saturates up on taken and down on not-taken, between 0 and 2^CTR_W-1.
    - If update_altdiff: u saturates up when pred_taken(update_ctr)==update_taken, else saturates down at 0.
    - The tag is rewritten unchanged.
  - Allocate, when update_provider=0:
    - If update_u==0: write the new tag, ctr = 2^(CTR_W-1) if taken else 2^(CTR_W-1)-1, u=0.
    - Otherwise: write only u = update_u-1 and pulse alloc_fail in the next cycle.
  - update_provider and update_alloc both set: the provider path wins and the alloc is ignored.
  - Updates are ignored while ready=0.
- State machine: INIT -> RUN -> UCLR -> RUN.
  - INIT: entered on rst. Sweeps idx 0..NUM_ENTRIES-1, one entry per cycle, writing tag=0, ctr=2^(CTR_W-1)-1 (weak not-taken), u=0. ready rises the cycle after the last write (NUM_ENTRIES cycles after rst deasserts).
  - RUN: a 32-bit update counter increments on each accepted update. When it reaches U_RESET_PERIOD-1 it wraps to 0 and the FSM enters UCLR.
  - UCLR: sweeps the u RAM to 0, one entry per cycle, over NUM_ENTRIES cycles.
    - ready stays 1.
    - Lookups still hit normally but report pred_u=0.
    - Provider and alloc writes to tag/ctr proceed; their u writes are dropped.
    - The update counter is held.
    - Returns to RUN after the last index.
- rst (asynchronous, active-high), including mid-sweep:
  - All outputs 0, sweep index 0, update counter 0, state INIT.
  - The sweep restarts from 0 after release.

Test Plan:
- Reset release -> ready=0 for exactly 1024 cycles, then 1. Lookups during INIT give pred_valid=1, pred_hit=0. After INIT, any lookup gives pred_hit=0, pred_ctr=3, pred_u=0.
- Alloc at pc=0x1000, ghr=0xA5A5, taken, update_u=0 -> next lookup of the same pc/ghr gives pred_hit=1, pred_ctr=4, pred_taken=1, pred_u=0. Same pc with ghr=0x5A5A gives pred_hit=0 unless the tag aliases.
- Provider updates: taken with update_ctr=7 -> ctr stays 7. Not-taken with ctr=0 -> stays 0. altdiff=1, correct, u=3 -> u stays 3. altdiff=0 -> u unchanged.
- Alloc with update_u=2 -> alloc_fail pulses for 1 cycle, entry u=1, tag/ctr unchanged. update_provider=1 and update_alloc=1 together -> no alloc_fail, provider update only.
- Lookup and update to the same idx in the same cycle -> response shows the new ctr/tag (bypass).
- With U_RESET_PERIOD=8 and NUM_ENTRIES=16: 8 updates -> UCLR for 16 cycles. During UCLR pred_u=0 and ctr writes take effect. Afterwards all u=0 and tags are preserved. Asserting rst mid-UCLR -> ready=0 and the INIT sweep restarts.
